// File: rtl/sobel_window_controller_if.sv
// sobel_window_controller_if: handshake bundle between the Sobel window controller and its environment.
// Signals:
//   frame_start                   frame start pulse
//   pix_in/pix_valid/pix_ready    raster pixel stream into the controller
//   windowBuffer                  3x3 window, [0]=top-left, [8]=newest pixel
//   start_calculations            window valid, gradient units compute
//   gx/gy, h_done/v_done          gradient magnitudes and their valid flags
//   edge_out/edge_valid/edge_ready  saturated edge magnitude stream
//   frame_done                    pulse after the last edge is accepted
//   busy                          controller not idle
// Modports: slave is the controller side, master is the environment side.
interface sobel_window_controller_if;
  logic              frame_start;
  logic [7:0]        pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [0:8][7:0]   windowBuffer;
  logic              start_calculations;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic              h_done;
  logic              v_done;
  logic [7:0]        edge_out;
  logic              edge_valid;
  logic              edge_ready;
  logic              frame_done;
  logic              busy;
  modport slave (
    input  frame_start, pix_in, pix_valid, gx, gy, h_done, v_done, edge_ready,
    output pix_ready, windowBuffer, start_calculations, edge_out, edge_valid, frame_done, busy
  );
  modport master (
    output frame_start, pix_in, pix_valid, gx, gy, h_done, v_done, edge_ready,
    input  pix_ready, windowBuffer, start_calculations, edge_out, edge_valid, frame_done, busy
  );
endinterface

// File: rtl/sobel_window_controller.sv
// sobel_window_controller: sequences one raster frame through the Sobel gradient datapath.
// Ports:
//   clk_i    system clock, rising edge
//   n_rst_i  asynchronous active-low reset
//   bus      sobel_window_controller_if.slave: pixel input, 3x3 window and start
//            to the gradient units, gx/gy with done flags, edge output stream,
//            frame_done pulse and busy flag
module sobel_window_controller #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic                       clk_i,
  input logic                       n_rst_i,
  sobel_window_controller_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  typedef enum logic [2:0] {IDLE, ACCEPT, CALC, OUT, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            last_q, last_d;
  logic [10:0]     mag_q, mag_d;
  logic [0:8][7:0] win_q;
  logic [7:0]      line0_q [IMG_WIDTH];
  logic [7:0]      line1_q [IMG_WIDTH];
  logic            accept;
  logic            unused_sign;
  assign accept = (state_q == ACCEPT) && bus.pix_valid;
  // gx/gy are absolute values; bit 10 is out of contract and ignored
  assign unused_sign = bus.gx[10] ^ bus.gy[10];
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: if (bus.frame_start) begin
        col_d   = '0;
        row_d   = '0;
        last_d  = 1'b0;
        state_d = ACCEPT;
      end
      ACCEPT: if (accept) begin
        col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        row_d   = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
        last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
        // only interior pixels complete a 3x3 window; border pixels yield no output
        state_d = (row_q >= RW'(2) && col_q >= CW'(2)) ? CALC : ACCEPT;
      end
      CALC: if (bus.h_done && bus.v_done) begin
        mag_d   = {1'b0, bus.gx[9:0]} + {1'b0, bus.gy[9:0]};
        state_d = OUT;
      end
      OUT:     if (bus.edge_ready) state_d = last_q ? DONE : ACCEPT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      mag_q   <= '0;
      win_q   <= '0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        line0_q[i] <= '0;
        line1_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      mag_q   <= mag_d;
      if (accept) begin
        // each window row shifts left; the right column comes from the two line buffers and the new pixel
        win_q <= {win_q[1], win_q[2], line0_q[col_q],
                  win_q[4], win_q[5], line1_q[col_q],
                  win_q[7], win_q[8], bus.pix_in};
        line0_q[col_q] <= line1_q[col_q];
        line1_q[col_q] <= bus.pix_in;
      end
    end
  end
  assign bus.pix_ready          = state_q == ACCEPT;
  assign bus.start_calculations = state_q == CALC;
  assign bus.edge_valid         = state_q == OUT;
  assign bus.frame_done         = state_q == DONE;
  assign bus.busy               = state_q != IDLE;
  assign bus.windowBuffer       = win_q;
  assign bus.edge_out           = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
  a_edge_hold: assert property (@(posedge clk_i) disable iff (!n_rst_i)
    bus.edge_valid && !bus.edge_ready |=> bus.edge_valid && $stable(bus.edge_out));
  a_done_pulse: assert property (@(posedge clk_i) disable iff (!n_rst_i)
    bus.frame_done |=> !bus.frame_done && !bus.busy);
endmodule
